// File: rtl/memory_scan_reader_if.sv
// Bus bundle between the scan reader, the addressed memory block and the downstream consumer.
// The master side addresses memory and presents bytes; the slave side returns data and accepts bytes.
interface memory_scan_reader_if #(
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr,
    input  mem_data,
    output out_data,
    output out_addr,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    input  out_data,
    input  out_addr,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/memory_scan_reader.sv
// Walks every memory address, lets each one settle, captures the byte and hands it downstream
// on a valid/ready handshake while accumulating a mod-256 checksum of the scan.
module memory_scan_reader #(
  parameter int NUM_BYTES     = 4,
  parameter int ADDR_W        = $clog2(NUM_BYTES),
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  memory_scan_reader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           checksum
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_BYTES - 1);

  generate
    if (NUM_BYTES < 2 || (NUM_BYTES & (NUM_BYTES - 1)) != 0) begin : g_bad_num_bytes
      $error("memory_scan_reader: NUM_BYTES must be a power of two and at least 2");
    end
    if (ADDR_W != $clog2(NUM_BYTES)) begin : g_bad_addr_w
      $error("memory_scan_reader: ADDR_W must equal clog2(NUM_BYTES)");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("memory_scan_reader: SETTLE_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PRESENT,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Abort is checked ahead of the per-state work so it overrides a same-edge handshake,
  // while IDLE ignores abort entirely so a simultaneous start still launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.mem_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      checksum      <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state         <= IDLE;
        cnt           <= '0;
        bus.mem_addr  <= '0;
        bus.out_valid <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= SETTLE;
              cnt          <= '0;
              bus.mem_addr <= '0;
              checksum     <= '0;
              busy         <= 1'b1;
            end
          end
          SETTLE: begin
            if (cnt == CNT_LAST) begin
              bus.out_data  <= bus.mem_data;
              bus.out_addr  <= bus.mem_addr;
              bus.out_valid <= 1'b1;
              checksum      <= checksum + bus.mem_data;
              state         <= PRESENT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PRESENT: begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              if (bus.mem_addr == ADDR_LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                bus.mem_addr <= bus.mem_addr + 1'b1;
                cnt          <= '0;
                state        <= SETTLE;
              end
            end
          end
          DONE: begin
            state        <= IDLE;
            bus.mem_addr <= '0;
            busy         <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
